pw_fifo_writer: RTL and testbench

Producer side of the pointwise-conv input FIFOs. Accepts byte-serial weight and activation streams and packs MAC_IN_NUM bytes into one wide word. It writes a programmed number of parameter words into the parameter FIFO, then a programmed number of pixel words into the data FIFO. The pointwise-conv engine drains both FIFOs through its fifo_rpram/fifo_rpe and fifo_rdata/fifo_rde ports.

---
 rtl/pw_fifo_writer.sv | 160 ++++++++++++++++
 tb/tb_pw_fifo_writer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pw_fifo_writer.sv
// Producer side of the pointwise-conv input FIFOs: packs byte-serial weight and
// activation streams into MAC_IN_NUM-byte words and writes them to the param/data FIFOs.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for start; lengths latched on accepted start
// S_PARAM | packing weight bytes, writing param_num words to the param FIFO
// S_DATA  | packing activation bytes, writing pixel_num words to the data FIFO
// S_DONE  | one-cycle done pulse, then back to idle
module pw_fifo_writer #(
  parameter int MAC_IN_NUM   = 10,
  parameter int DATA_WIDTH   = 8,
  parameter int CNT_WIDTH    = 10,
  parameter int MAC_IN_WIDTH = MAC_IN_NUM * DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  input  logic [CNT_WIDTH-1:0]    param_num,
  input  logic [CNT_WIDTH-1:0]    pixel_num,
  input  logic [DATA_WIDTH-1:0]   wgt_in,
  input  logic                    wgt_valid,
  output logic                    wgt_ready,
  input  logic [DATA_WIDTH-1:0]   act_in,
  input  logic                    act_valid,
  output logic                    act_ready,
  output logic [MAC_IN_WIDTH-1:0] fifo_wpram,
  output logic                    fifo_wpe,
  input  logic                    fifo_pfull,
  output logic [MAC_IN_WIDTH-1:0] fifo_wdata,
  output logic                    fifo_wde,
  input  logic                    fifo_wfull,
  output logic                    busy,
  output logic                    done
);

  localparam int BCW = (MAC_IN_NUM > 1) ? $clog2(MAC_IN_NUM) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PARAM,
    S_DATA,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [CNT_WIDTH-1:0]    param_len;
  logic [CNT_WIDTH-1:0]    pixel_len;
  logic [CNT_WIDTH-1:0]    word_cnt;
  logic [CNT_WIDTH-1:0]    word_cnt_inc;
  logic [CNT_WIDTH-1:0]    word_len;
  logic [BCW-1:0]          byte_cnt;
  logic [MAC_IN_WIDTH-1:0] pack;
  logic [MAC_IN_WIDTH-1:0] wpram_q;
  logic [MAC_IN_WIDTH-1:0] wdata_q;
  logic                    pending;
  logic                    in_param;
  logic                    in_data;
  logic                    byte_fire;
  logic                    fifo_full;
  logic                    wr_fire;
  logic                    word_last;
  logic                    job_start;
  logic [DATA_WIDTH-1:0]   byte_in;

  always_comb begin
    in_param     = (state == S_PARAM);
    in_data      = (state == S_DATA);
    job_start    = (state == S_IDLE) && start;
    wgt_ready    = in_param && !pending;
    act_ready    = in_data && !pending;
    byte_fire    = (wgt_valid && wgt_ready) || (act_valid && act_ready);
    byte_in      = in_param ? wgt_in : act_in;
    fifo_full    = in_param ? fifo_pfull : fifo_wfull;
    wr_fire      = pending && (in_param || in_data) && !fifo_full;
    fifo_wpe     = wr_fire && in_param;
    fifo_wde     = wr_fire && in_data;
    word_len     = in_param ? param_len : pixel_len;
    word_cnt_inc = word_cnt + 1'b1;
    word_last    = wr_fire && (word_cnt_inc == word_len);
    // Word is presented straight from the pack register on the enable cycle;
    // otherwise the last written word is held.
    fifo_wpram   = fifo_wpe ? pack : wpram_q;
    fifo_wdata   = fifo_wde ? pack : wdata_q;
    busy         = in_param || in_data;
    done         = (state == S_DONE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (param_num != '0)      state_nxt = S_PARAM;
          else if (pixel_num != '0) state_nxt = S_DATA;
          else                      state_nxt = S_DONE;
        end
      end
      S_PARAM: begin
        if (word_last) state_nxt = (pixel_len != '0) ? S_DATA : S_DONE;
      end
      S_DATA: begin
        if (word_last) state_nxt = S_DONE;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      param_len <= '0;
      pixel_len <= '0;
      word_cnt  <= '0;
      byte_cnt  <= '0;
      pending   <= 1'b0;
      pack      <= '0;
      wpram_q   <= '0;
      wdata_q   <= '0;
    end else begin
      if (job_start) begin
        param_len <= param_num;
        pixel_len <= pixel_num;
        word_cnt  <= '0;
        byte_cnt  <= '0;
        pending   <= 1'b0;
      end
      if (byte_fire) begin
        for (int k = 0; k < MAC_IN_NUM; k++) begin
          if (byte_cnt == BCW'(k)) pack[k*DATA_WIDTH +: DATA_WIDTH] <= byte_in;
        end
        if (byte_cnt == BCW'(MAC_IN_NUM - 1)) begin
          byte_cnt <= '0;
          pending  <= 1'b1;
        end else begin
          byte_cnt <= byte_cnt + 1'b1;
        end
      end
      if (wr_fire) begin
        pending  <= 1'b0;
        // Counter restarts on the last word so the data phase counts from zero.
        word_cnt <= word_last ? '0 : word_cnt_inc;
        if (in_param) wpram_q <= pack;
        if (in_data)  wdata_q <= pack;
      end
    end
  end

endmodule

// File: tb/tb_pw_fifo_writer.sv
// Self-checking bench for pw_fifo_writer: byte sources advance only on handshake,
// expected words are queued at job start and compared as the FIFO enables fire.
module tb_pw_fifo_writer;
  localparam int N  = 10;
  localparam int DW = 8;
  localparam int CW = 10;
  localparam int MW = N * DW;

  logic          clk;
  logic          rstn;
  logic          start;
  logic [CW-1:0] param_num;
  logic [CW-1:0] pixel_num;
  logic [DW-1:0] wgt_in;
  logic          wgt_valid;
  logic          wgt_ready;
  logic [DW-1:0] act_in;
  logic          act_valid;
  logic          act_ready;
  logic [MW-1:0] fifo_wpram;
  logic          fifo_wpe;
  logic          fifo_pfull;
  logic [MW-1:0] fifo_wdata;
  logic          fifo_wde;
  logic          fifo_wfull;
  logic          busy;
  logic          done;

  pw_fifo_writer #(.MAC_IN_NUM(N), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rstn(rstn), .start(start),
    .param_num(param_num), .pixel_num(pixel_num),
    .wgt_in(wgt_in), .wgt_valid(wgt_valid), .wgt_ready(wgt_ready),
    .act_in(act_in), .act_valid(act_valid), .act_ready(act_ready),
    .fifo_wpram(fifo_wpram), .fifo_wpe(fifo_wpe), .fifo_pfull(fifo_pfull),
    .fifo_wdata(fifo_wdata), .fifo_wde(fifo_wde), .fifo_wfull(fifo_wfull),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int pat = 0;
  bit rnd_w = 0, rnd_a = 0;
  int w_idx = 0, a_idx = 0;
  int n_wpe = 0, n_wde = 0, n_done = 0, n_wr = 0, n_ar = 0;
  int b_wpe, b_wde, b_done, b_wr, b_ar, b_a;
  int job_pn, job_xn;
  logic [MW-1:0] q_p[$];
  logic [MW-1:0] q_d[$];
  logic [MW-1:0] last_wpram_obs = '0, last_wdata_obs = '0, last_wdata_exp = '0;

  task automatic chk(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [DW-1:0] pat_byte(input int idx);
    if (pat == 0) return DW'((idx % 10) + 1);
    return DW'((idx * 37 + 11) % 256);
  endfunction

  function automatic logic [MW-1:0] exp_word(input int base);
    logic [MW-1:0] w;
    w = '0;
    for (int k = 0; k < N; k++) w[k*DW +: DW] = pat_byte(base + k);
    return w;
  endfunction

  // Byte sources: data and valid are held until the handshake completes.
  initial begin
    bit acc_w, acc_a;
    wgt_valid = 1'b0; act_valid = 1'b0;
    wgt_in = pat_byte(0); act_in = pat_byte(0);
    forever begin
      @(negedge clk);
      acc_w = wgt_valid && wgt_ready;
      acc_a = act_valid && act_ready;
      @(posedge clk);
      #1;
      if (acc_w) w_idx++;
      if (acc_a) a_idx++;
      if (!wgt_valid || acc_w) wgt_valid = rnd_w ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (!act_valid || acc_a) act_valid = rnd_a ? ($urandom_range(0, 2) != 0) : 1'b1;
      wgt_in = pat_byte(w_idx);
      act_in = pat_byte(a_idx);
    end
  end

  // Output monitor / scoreboard pop.
  initial begin
    logic [MW-1:0] e;
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (fifo_wpe) begin
          n_wpe++;
          last_wpram_obs = fifo_wpram;
          if (q_p.size() == 0) chk("wpe_extra", 1, 0);
          else begin e = q_p.pop_front(); chk("wpram", fifo_wpram, e); end
        end
        if (fifo_wde) begin
          n_wde++;
          last_wdata_obs = fifo_wdata;
          if (q_d.size() == 0) chk("wde_extra", 1, 0);
          else begin e = q_d.pop_front(); last_wdata_exp = e; chk("wdata", fifo_wdata, e); end
        end
        if (done) n_done++;
        if (wgt_ready) n_wr++;
        if (act_ready) n_ar++;
      end
    end
  end

  task automatic start_job(input int pn, input int xn);
    @(negedge clk);
    for (int i = 0; i < pn; i++) q_p.push_back(exp_word(w_idx + i * N));
    for (int i = 0; i < xn; i++) q_d.push_back(exp_word(a_idx + i * N));
    b_wpe = n_wpe; b_wde = n_wde; b_done = n_done; b_wr = n_wr; b_ar = n_ar; b_a = a_idx;
    job_pn = pn; job_xn = xn;
    param_num = CW'(pn); pixel_num = CW'(xn); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (pn != 0 || xn != 0) chk("busy_run", MW'(busy), 1);
  endtask

  task automatic wait_done(input int budget);
    int t = 0;
    while (done !== 1'b1 && t < budget) begin @(negedge clk); t++; end
    if (done === 1'b1) chk("busy_at_done", MW'(busy), 0);
    else chk("done_timeout", 0, 1);
    repeat (2) @(negedge clk);
    chk("done_once", MW'(n_done - b_done), 1);
    chk("wpe_count", MW'(n_wpe - b_wpe), MW'(job_pn));
    chk("wde_count", MW'(n_wde - b_wde), MW'(job_xn));
    chk("busy_idle", MW'(busy), 0);
    chk("q_drained", MW'(q_p.size() + q_d.size()), 0);
  endtask

  initial begin
    logic [MW-1:0] exp_first;
    int t;
    rstn = 1'b0; start = 1'b0; param_num = '0; pixel_num = '0;
    fifo_pfull = 1'b0; fifo_wfull = 1'b0;
    #12;
    chk("rst_ctrl", MW'({wgt_ready, act_ready, fifo_wpe, fifo_wde, busy, done}), 0);
    chk("rst_wpram", fifo_wpram, 0);
    chk("rst_wdata", fifo_wdata, 0);
    @(negedge clk); rstn = 1'b1;

    // 1: one param word, two data words of the 0x01..0x0A pattern
    start_job(1, 2);
    wait_done(200);
    chk("t1_pword", last_wpram_obs, 80'h0A090807060504030201);
    chk("t1_dword", last_wdata_obs, 80'h0A090807060504030201);

    // 2: data only
    start_job(0, 3);
    wait_done(200);
    chk("t2_wgt_ready", MW'(n_wr - b_wr), 0);

    // 3: empty job
    start_job(0, 0);
    wait_done(5);
    chk("t3_wgt_ready", MW'(n_wr - b_wr), 0);
    chk("t3_act_ready", MW'(n_ar - b_ar), 0);

    // 4: data FIFO full when the first word completes
    fifo_wfull = 1'b1;
    start_job(0, 2);
    t = 0;
    while (a_idx < b_a + N && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) chk("t4_fill_timeout", 0, 1);
    exp_first = q_d[0];
    for (int i = 0; i < 20; i++) begin
      chk("t4_wde_stall", MW'(fifo_wde), 0);
      chk("t4_ready_stall", MW'(act_ready), 0);
      chk("t4_wdata_hold", fifo_wdata, last_wdata_exp);
      @(negedge clk);
    end
    @(posedge clk); #1; fifo_wfull = 1'b0;
    @(negedge clk);
    chk("t4_wde_release", MW'(fifo_wde), 1);
    chk("t4_wdata_release", fifo_wdata, exp_first);
    wait_done(200);

    // 5: random valid gaps on both streams, non-repeating byte pattern
    pat = 1; rnd_w = 1; rnd_a = 1;
    start_job(3, 5);
    wait_done(2000);
    start_job(0, 7);
    wait_done(2000);
    rnd_w = 0; rnd_a = 0;

    // 6: reset in the middle of a data word, then a clean job
    start_job(0, 3);
    t = 0;
    while (a_idx < b_a + 5 && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) chk("t6_fill_timeout", 0, 1);
    @(posedge clk); #2;
    rstn = 1'b0;
    #1;
    chk("t6_rst_ctrl", MW'({wgt_ready, act_ready, fifo_wpe, fifo_wde, busy, done}), 0);
    chk("t6_rst_wpram", fifo_wpram, 0);
    chk("t6_rst_wdata", fifo_wdata, 0);
    q_p.delete(); q_d.delete();
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    start_job(1, 2);
    wait_done(300);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
